muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV32M execute unit that carries out the multiply/divide instructions flagged by the decode stage as M-type (opcode 0110011, func7 0000001). It sits in the execute stage beside the integer ALU. It accepts one operation at a time via a start pulse, stalls the pipeline while it computes, and returns a 32-bit result plus destination register with a one-cycle done pulse.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  issue; decode m_type_inst qualified by a valid instruction in execute.
- flush  in  1  synchronous abort of any in-flight operation.
- func3  in  3  M-op select.
- rs1_data  in  XLEN  operand A (dividend/multiplicand).
- rs2_data  in  XLEN  operand B (divisor/multiplier).
- rd_in  in  5  destination register of the issued op.
- busy  out  1  state != IDLE.
- stall  out  1  hold fetch/decode/execute.
- done  out  1  one-cycle pulse; result and rd_out valid.
- result  out  XLEN  registered result.
- rd_out  out  5  registered destination.

## Operation
- func3 encodings: 000 MUL (low 32 bits), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, start=1: latch func3, operands, and rd_in.
    - Multiply op, div-by-zero, or signed overflow: go to MUL.
    - Otherwise: go to DIV with iteration count 0.
  - MUL: write result, go to DONE.
  - DIV: one restoring step per cycle on operand magnitudes; after the 32nd step, apply sign correction, write result, go to DONE.
  - DONE: done=1, then go to IDLE.
- start is ignored when state != IDLE.
- Multiply: sign-extend or zero-extend both operands to 33 bits per func3, form the 66-bit product, take bits [31:0] or [63:32].
- Divide:
  - Signed ops divide absolute values.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero:
  - DIV/DIVU result 0xFFFFFFFF.
  - REM/REMU result = rs1_data.
- Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF):
  - DIV result 0x80000000.
  - REM result 0.
- stall = (state==IDLE & start) | state==MUL | state==DIV. stall is low in DONE so the pipeline advances with the result.
- flush: next state IDLE; no done; result and rd_out keep their previous values. flush has priority over start and over every FSM transition.
- rst: state IDLE, done 0, result 0, rd_out 0, count 0.

## Timing
- Start is sampled in cycle 0.
- MUL, div-by-zero, and overflow: done in cycle 2; stall high in cycles 0–1.
- Normal divide: DIV occupies cycles 1–32; done in cycle 33; stall high in cycles 0–32.
- A new start is accepted in the cycle after DONE at the earliest (IDLE). start asserted during DONE is ignored.
- result and rd_out hold their values until the next DONE.
- flush or rst asserted together with start: the op is not accepted.

## Structure
- Shared package muldiv_pkg holds:
  - func3 localparams: F3_MUL … F3_REMU.
  - FSM state encodings.
  - DIV_STEPS=32.
- Sub-module div_core: the 32-step restoring unsigned divider.
  - Inputs: load, dividend, divisor.
  - Outputs: quotient, remainder, last_step.
  - Sign handling and special cases stay in muldiv_unit.

## Test plan
- MUL 7×(−3) (rs2=0xFFFFFFFD) -> done in cycle 2, result 0xFFFFFFEB; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> done in cycle 33, result 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; stall high cycles 0–32.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each done in cycle 2; DIV 0x80000000/−1 -> 0x80000000, REM -> 0.
- flush in cycle 10 of a DIV -> IDLE in cycle 11, no done pulse, previous result retained; a following MUL completes normally.
- start held high through a DIV -> exactly one done; rst in mid-DIV -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide execute unit.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam int DIV_STEPS = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic is_signed_div(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/div_core.sv
// 32-step restoring unsigned divider, one quotient bit per cycle.
module div_core
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        last_step
);

   localparam logic [5:0] STEPS = 6'(DIV_STEPS);

   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvs;
   logic [5:0]  r_cnt;

   logic [32:0] w_sh;
   logic [32:0] w_diff;
   logic        w_qbit;

   assign w_sh      = {r_rem, r_quo[31]};
   assign w_diff    = w_sh - {1'b0, r_dvs};
   assign w_qbit    = ~w_diff[32];
   // Outputs are the post-step values so the caller can capture on the last step.
   assign quotient  = {r_quo[30:0], w_qbit};
   assign remainder = w_qbit ? w_diff[31:0] : w_sh[31:0];
   assign last_step = (r_cnt == STEPS - 6'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem <= '0;
         r_quo <= '0;
         r_dvs <= '0;
         r_cnt <= '0;
      end else if (load) begin
         r_rem <= '0;
         r_quo <= dividend;
         r_dvs <= divisor;
         r_cnt <= '0;
      end else if (r_cnt != STEPS) begin
         r_rem <= remainder;
         r_quo <= quotient;
         r_cnt <= r_cnt + 6'd1;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit beside the execute-stage ALU.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   state_t      r_state;
   logic [2:0]  r_f3;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [4:0]  r_rd;
   logic [31:0] r_result;
   logic [4:0]  r_rd_out;
   logic        r_done;

   logic        w_in_sgn;
   logic        w_in_dz;
   logic        w_in_ovf;
   logic        w_in_fast;
   logic        w_load;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic        w_last;

   assign w_in_sgn  = is_signed_div(func3);
   assign w_in_dz   = (rs2_data == 32'd0);
   assign w_in_ovf  = w_in_sgn && (rs1_data == 32'h8000_0000)
                      && (rs2_data == 32'hFFFF_FFFF);
   assign w_in_fast = ~func3[2] | w_in_dz | w_in_ovf;
   assign w_abs_a   = (w_in_sgn & rs1_data[31]) ? -rs1_data : rs1_data;
   assign w_abs_b   = (w_in_sgn & rs2_data[31]) ? -rs2_data : rs2_data;
   assign w_load    = (r_state == S_IDLE) & start & ~flush & ~w_in_fast;

   div_core u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .dividend  (w_abs_a),
      .divisor   (w_abs_b),
      .quotient  (w_quo),
      .remainder (w_rem),
      .last_step (w_last)
   );

   // Low 64 bits of the sign/zero-extended product equal the 66-bit product.
   logic        w_sa;
   logic        w_sb;
   logic [63:0] w_ax;
   logic [63:0] w_bx;
   logic [63:0] w_prod;

   assign w_sa   = (r_f3 == F3_MULH) | (r_f3 == F3_MULHSU);
   assign w_sb   = (r_f3 == F3_MULH);
   assign w_ax   = {{32{w_sa & r_a[31]}}, r_a};
   assign w_bx   = {{32{w_sb & r_b[31]}}, r_b};
   assign w_prod = w_ax * w_bx;

   logic        w_r_sgn;
   logic        w_r_dz;
   logic [31:0] w_fast_res;
   logic [31:0] w_div_res;

   assign w_r_sgn = is_signed_div(r_f3);
   assign w_r_dz  = (r_b == 32'd0);

   always_comb begin
      w_div_res = '0;
      if (r_f3[1])
         w_div_res = (w_r_sgn & r_a[31]) ? -w_rem : w_rem;
      else
         w_div_res = (w_r_sgn & (r_a[31] ^ r_b[31])) ? -w_quo : w_quo;
   end

   // Division ops only reach MUL state on divide-by-zero or signed overflow.
   always_comb begin
      w_fast_res = '0;
      unique case (r_f3)
         F3_MUL:                      w_fast_res = w_prod[31:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_fast_res = w_prod[63:32];
         F3_DIV, F3_DIVU:             w_fast_res = w_r_dz ? 32'hFFFF_FFFF : r_a;
         F3_REM, F3_REMU:             w_fast_res = w_r_dz ? r_a : 32'd0;
         default:                     w_fast_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_f3     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_rd     <= '0;
         r_result <= '0;
         r_rd_out <= '0;
         r_done   <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_f3    <= func3;
                  r_a     <= rs1_data;
                  r_b     <= rs2_data;
                  r_rd    <= rd_in;
                  r_state <= w_in_fast ? S_MUL : S_DIV;
               end
            end
            S_MUL: begin
               r_result <= w_fast_res;
               r_rd_out <= r_rd;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DIV: begin
               if (w_last) begin
                  r_result <= w_div_res;
                  r_rd_out <= r_rd;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign stall  = ((r_state == S_IDLE) & start)
                   | (r_state == S_MUL) | (r_state == S_DIV);
   assign done   = r_done;
   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: results, latency, stall, flush and reset.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  func3 = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [4:0]  rd_in = '0;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   muldiv_unit #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .flush    (flush),
      .func3    (func3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .busy     (busy),
      .stall    (stall),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          lat;
      int          c0;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_done = 0;
   bit   mon_en = 1'b1;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      ub;
      logic [63:0] p;
      int          ia;
      int          ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      ia = $signed(a);
      ib = $signed(b);
      p  = '0;
      case (f3)
         F3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
         F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         F3_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         F3_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(ia % ib);
         end
         default:   return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      if (!f3[2] || b == 0) return 2;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000
          && b == 32'hFFFF_FFFF) return 2;
      return 33;
   endfunction

   // Monitor: checks stall against the front op and scores every done pulse.
   always @(negedge clk) begin
      if (mon_en && q.size() != 0)
         chk("stall", 32'(stall), 32'((cyc - q[0].c0) < q[0].lat));
      if (done) begin
         n_done++;
         if (q.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", result, e.res);
            chk("rd_out", 32'(rd_out), 32'(e.rd));
            chk("latency", 32'(cyc - e.c0), 32'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
      exp_t e;
      @(posedge clk);
      #2;
      start    = 1'b1;
      func3    = f3;
      rs1_data = a;
      rs2_data = b;
      rd_in    = rd;
      e.res = exp_res;
      e.rd  = rd;
      e.lat = exp_lat;
      e.c0  = cyc;
      q.push_back(e);
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (q.size() != 0 && n < 80) begin
         @(negedge clk);
         n++;
      end
      chk("timeout", 32'(q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic run_ref(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
      issue(f3, a, b, rd, ref_op(f3, a, b), ref_lat(f3, a, b));
      wait_empty();
   endtask

   initial begin
      int c0;
      logic [31:0] keep;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_rd", 32'(rd_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 2);
      wait_empty();
      issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2);
      wait_empty();
      issue(F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 2);
      wait_empty();
      issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 2);
      wait_empty();
      issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 33);
      wait_empty();
      issue(F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33);
      wait_empty();
      issue(F3_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33);
      wait_empty();
      issue(F3_REMU, 32'd100, 32'd7, 5'd8, 32'd2, 33);
      wait_empty();
      issue(F3_DIVU, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2);
      wait_empty();
      issue(F3_REM, 32'd5, 32'd0, 5'd10, 32'd5, 2);
      wait_empty();
      issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 2);
      wait_empty();
      issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 2);
      wait_empty();

      for (int i = 0; i < 8; i++)
         run_ref(3'(i), $urandom, $urandom_range(1, 1000) ^ (i[0] ? 32'h8000_0000 : 32'd0),
                 5'(i + 16));

      // Flush in cycle 10 of a divide.
      keep = result;
      issue(F3_DIVU, 32'd1000, 32'd3, 5'd13, 32'd333, 33);
      c0 = q[0].c0;
      while (cyc < c0 + 10) @(posedge clk);
      #2;
      mon_en = 1'b0;
      q.delete();
      flush = 1'b1;
      @(posedge clk);
      #2;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 32'(busy), 32'd0);
      n_done = 0;
      repeat (30) @(negedge clk);
      chk("flush_nodone", 32'(n_done), 32'd0);
      chk("flush_keep", result, keep);
      mon_en = 1'b1;
      issue(F3_MUL, 32'd6, 32'd9, 5'd14, 32'd54, 2);
      wait_empty();

      // start held high from issue through the DONE cycle.
      n_done = 0;
      @(posedge clk);
      #2;
      start    = 1'b1;
      func3    = F3_DIVU;
      rs1_data = 32'd90;
      rs2_data = 32'd9;
      rd_in    = 5'd15;
      begin
         exp_t e;
         e.res = 32'd10;
         e.rd  = 5'd15;
         e.lat = 33;
         e.c0  = cyc;
         q.push_back(e);
      end
      repeat (34) @(posedge clk);
      #2;
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("held_one_done", 32'(n_done), 32'd1);
      chk("held_q", 32'(q.size()), 32'd0);

      // Reset in the middle of a divide.
      issue(F3_DIV, 32'd77, 32'd5, 5'd17, 32'd15, 33);
      repeat (8) @(posedge clk);
      #2;
      mon_en = 1'b0;
      q.delete();
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_result", result, 32'd0);
      chk("mrst_rd", 32'(rd_out), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_stall", 32'(stall), 32'd0);
      mon_en = 1'b1;
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
